// File: rtl/cpu_pkg.sv
// Shared CPU types: the write-back retire entry layout and debug trace widths.
package cpu_pkg;

    localparam int CPU_XLEN = 32;
    localparam int CPU_AW   = 5;
    localparam int DBG_WE_W = 4;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic                gr_we;
        logic [CPU_AW-1:0]   dest;
        logic [CPU_XLEN-1:0] result;
    } wb_entry_t;

    // An entry only touches the register file if it writes a non-zero register.
    function automatic logic writes_rf(input wb_entry_t e);
        return e.gr_we && (e.dest != '0);
    endfunction

endpackage

// File: rtl/wb_retire_fifo.sv
// Retire-queue storage: DEPTH entries with wrapping head/tail pointers and an occupancy count.
module wb_retire_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  wb_entry_t     push_entry_i,
    output wb_entry_t     entries_o [DEPTH],
    output logic [PW-1:0] head_ptr_o,
    output logic [CW-1:0] count_o
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Caller guarantees push only when not full and pop only when not empty.
    always_comb begin
        head_d  = head_q + PW'(pop_i);
        tail_d  = tail_q + PW'(push_i);
        count_d = count_q + CW'(push_i) - CW'(pop_i);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    assign entries_o  = mem_q;
    assign head_ptr_o = head_q;
    assign count_o    = count_q;

endmodule

// File: rtl/wb_retire_stage.sv
// Write-back retire stage: queues MEM results, arbitrates for the RF write port, forwards to ID.
// Optional trace ports are enabled with the WB_DEBUG_EN macro.
module wb_retire_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = CPU_XLEN,
    parameter int AW    = CPU_AW,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [XLEN-1:0] mem_pc,
    input  logic            mem_gr_we,
    input  logic [AW-1:0]   mem_dest,
    input  logic [XLEN-1:0] mem_result,
    input  logic            flush,
    output logic            rf_req,
    input  logic            rf_grant,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    output logic            id_rs1_hit,
    output logic            id_rs2_hit,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [31:0]     retire_cnt
`ifdef WB_DEBUG_EN
    ,
    output logic [XLEN-1:0]     debug_wb_pc,
    output logic [DBG_WE_W-1:0] debug_wb_rf_we,
    output logic [AW-1:0]       debug_wb_rf_wnum,
    output logic [XLEN-1:0]     debug_wb_rf_wdata
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     push_entry;
    wb_entry_t     entries [DEPTH];
    wb_entry_t     head;
    logic [PW-1:0] head_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          retire;
    logic [31:0]   retire_cnt_q, retire_cnt_d;

    assign push_entry = '{pc: mem_pc, gr_we: mem_gr_we, dest: mem_dest, result: mem_result};

    // Outputs are masked by resetn so stale occupancy never shows during the reset cycle.
    assign mem_ready = !resetn || (count != CW'(DEPTH));
    assign push      = mem_valid && mem_ready;
    assign rf_req    = resetn && (count != '0);
    assign retire    = rf_req && rf_grant;

    wb_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (push),
        .pop_i        (retire),
        .flush_i      (flush),
        .push_entry_i (push_entry),
        .entries_o    (entries),
        .head_ptr_o   (head_ptr),
        .count_o      (count)
    );

    assign head     = entries[head_ptr];
    assign rf_we    = retire && writes_rf(head);
    assign rf_waddr = head.dest;
    assign rf_wdata = head.result;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        id_rs1_hit  = 1'b0;
        id_rs1_data = '0;
        id_rs2_hit  = 1'b0;
        id_rs2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (resetn && (CW'(k) < count) && writes_rf(entries[head_ptr + PW'(k)])) begin
                if (entries[head_ptr + PW'(k)].dest == id_rs1) begin
                    id_rs1_hit  = 1'b1;
                    id_rs1_data = entries[head_ptr + PW'(k)].result;
                end
                if (entries[head_ptr + PW'(k)].dest == id_rs2) begin
                    id_rs2_hit  = 1'b1;
                    id_rs2_data = entries[head_ptr + PW'(k)].result;
                end
            end
        end
    end

    assign retire_cnt_d = retire_cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

`ifdef WB_DEBUG_EN
    assign debug_wb_pc       = head.pc;
    assign debug_wb_rf_we    = {DBG_WE_W{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    logic unused_head_pc;
    assign unused_head_pc = ^head.pc;
`endif

endmodule
